// File: rtl/fma_operand_classify.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fma_operand_classify : two-stage X/Y/Z special-case classifier for FMA   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fma_operand_classify #(
   parameter int FLEN = 64,
   parameter int NE   = 11
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FLEN-1:0] x,
   input  logic [FLEN-1:0] y,
   input  logic [FLEN-1:0] z,
   input  logic [2:0]      frm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            xsign,
   output logic            ysign,
   output logic            zsign,
   output logic            xinf,
   output logic            yinf,
   output logic            inf,
   output logic            nan,
   output logic            snan,
   output logic            invalid,
   output logic            killprod,
   output logic            rm
);

   localparam int NF = FLEN - NE - 1;

   logic [2:0][FLEN-1:0] ops;
   logic [2:0] sign_d, expmax_d, expzero_d, fraczero_d, fracmsb_d;
   logic [2:0] s1_sign_q, s1_expmax_q, s1_expzero_q, s1_fraczero_q, s1_fracmsb_q;
   logic       s1_rm_q, s1_valid_q, s2_valid_q;
   logic       s2_adv, s1_adv;

   assign ops = {z, y, x};

   for (genvar g = 0; g < 3; g++) begin : g_dec
      assign sign_d[g]     = ops[g][FLEN-1];
      assign expmax_d[g]   = &ops[g][FLEN-2:NF];
      assign expzero_d[g]  = ~|ops[g][FLEN-2:NF];
      assign fraczero_d[g] = ~|ops[g][NF-1:0];
      assign fracmsb_d[g]  = ops[g][NF-1];
   end

   logic [2:0] opinf, opnan, opsnan, opzero;
   logic       inf_d, nan_d, snan_d, invalid_d, killprod_d;

   always_comb begin
      opinf      = s1_expmax_q & s1_fraczero_q;
      opnan      = s1_expmax_q & ~s1_fraczero_q;
      opsnan     = opnan & ~s1_fracmsb_q;
      opzero     = s1_expzero_q & s1_fraczero_q;
      inf_d      = |opinf;
      nan_d      = |opnan;
      snan_d     = |opsnan;
      killprod_d = opzero[0] | opzero[1];
      // inf*0 and inf-inf are raised independently of whether Z is a quiet NaN
      invalid_d  = snan_d
                 | (opinf[0] & opzero[1])
                 | (opinf[1] & opzero[0])
                 | ((opinf[0] | opinf[1]) & opinf[2] & (^s1_sign_q) & ~opnan[0] & ~opnan[1]);
   end

   // Combinational ready: a stalled consumer back-pressures straight to the input
   assign s2_adv    = ~s2_valid_q | out_ready;
   assign s1_adv    = ~s1_valid_q | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= '0;
         s1_expmax_q   <= '0;
         s1_expzero_q  <= '0;
         s1_fraczero_q <= '0;
         s1_fracmsb_q  <= '0;
         s1_rm_q       <= 1'b0;
      end else begin
         if (s1_adv) s1_valid_q <= in_valid;
         if (in_valid & s1_adv) begin
            s1_sign_q     <= sign_d;
            s1_expmax_q   <= expmax_d;
            s1_expzero_q  <= expzero_d;
            s1_fraczero_q <= fraczero_d;
            s1_fracmsb_q  <= fracmsb_d;
            s1_rm_q       <= (frm == 3'b010);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_q <= 1'b0;
         xsign      <= 1'b0;
         ysign      <= 1'b0;
         zsign      <= 1'b0;
         xinf       <= 1'b0;
         yinf       <= 1'b0;
         inf        <= 1'b0;
         nan        <= 1'b0;
         snan       <= 1'b0;
         invalid    <= 1'b0;
         killprod   <= 1'b0;
         rm         <= 1'b0;
      end else begin
         if (s2_adv) s2_valid_q <= s1_valid_q;
         if (s1_valid_q & s2_adv) begin
            xsign    <= s1_sign_q[0];
            ysign    <= s1_sign_q[1];
            zsign    <= s1_sign_q[2];
            xinf     <= opinf[0];
            yinf     <= opinf[1];
            inf      <= inf_d;
            nan      <= nan_d;
            snan     <= snan_d;
            invalid  <= invalid_d;
            killprod <= killprod_d;
            rm       <= s1_rm_q;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fma_operand_classify.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fma_operand_classify : directed self-checking bench                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fma_operand_classify;

   logic        clk, reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] x, y, z;
   logic [2:0]  frm;
   logic        xsign, ysign, zsign, xinf, yinf, inf, nan, snan, invalid, killprod, rm;
   logic [10:0] obs;

   int n_checks = 0;
   int n_errors = 0;

   fma_operand_classify #(.FLEN(64), .NE(11)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .z(z), .frm(frm), .out_valid(out_valid), .out_ready(out_ready),
      .xsign(xsign), .ysign(ysign), .zsign(zsign), .xinf(xinf), .yinf(yinf),
      .inf(inf), .nan(nan), .snan(snan), .invalid(invalid), .killprod(killprod), .rm(rm)
   );

   // {xsign,ysign,zsign,xinf,yinf,inf,nan,snan,invalid,killprod,rm}
   assign obs = {xsign, ysign, zsign, xinf, yinf, inf, nan, snan, invalid, killprod, rm};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [63:0] x, y, z;
      logic [2:0]  frm;
      logic [10:0] e;
   } vec_t;

   vec_t vt[11];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int k);
      x   = vt[k].x;
      y   = vt[k].y;
      z   = vt[k].z;
      frm = vt[k].frm;
   endtask

   task automatic run_one(input int k);
      int lat;
      @(negedge clk);
      drive(k);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 check($sformatf("v%0d_in_ready", k), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d_out_valid", k), out_valid, 1);
      check($sformatf("v%0d_latency", k), lat, 2);
      check($sformatf("v%0d_flags", k), obs, vt[k].e);
      @(negedge clk);
      check($sformatf("v%0d_bubble", k), out_valid, 0);
   endtask

   initial begin
      int sent, got;
      logic acc;
      //          x                      y                      z                      frm     expected
      vt[0]  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'hBFF0000000000000, 3'b000, 11'b00100000000};
      vt[1]  = '{64'h7FF0000000000000, 64'h0000000000000000, 64'h3FF0000000000000, 3'b000, 11'b00010100110};
      vt[2]  = '{64'h7FF0000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000, 3'b000, 11'b00110100100};
      vt[3]  = '{64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 3'b000, 11'b00010100000};
      vt[4]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000001, 3'b010, 11'b00000011101};
      vt[5]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 3'b010, 11'b00000010001};
      vt[6]  = '{64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 3'b000, 11'b00010110110};
      vt[7]  = '{64'h0000000000000001, 64'h7FF0000000000000, 64'h3FF0000000000000, 3'b000, 11'b00001100000};
      vt[8]  = '{64'h8000000000000000, 64'hFFF0000000000000, 64'h7FF0000000000000, 3'b011, 11'b11001100110};
      vt[9]  = '{64'hFFF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 3'b000, 11'b10010100100};
      vt[10] = '{64'hFFF0000000000000, 64'hC000000000000000, 64'h7FF0000000000000, 3'b000, 11'b11010100000};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; y = '0; z = '0; frm = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_flags", obs, 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < 11; k++) run_one(k);

      // Four back-to-back triples, consumer stalled for the first three valid cycles
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         if (sent < 4) begin
            drive(sent);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 2) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_accepted", sent, 2);
         end
         if (cyc >= 2 && cyc <= 4) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_hold", obs, vt[0].e);
         end
         if (out_valid && out_ready) begin
            check($sformatf("stream_%0d_flags", got), obs, vt[got].e);
            check($sformatf("stream_%0d_cycle", got), cyc, 5 + got);
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) sent++;
      end
      check("stream_count", got, 4);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("stream_drained", out_valid, 0);

      // Fill the pipe, then reset it
      @(negedge clk);
      drive(8); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      drive(9);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("full_out_valid", out_valid, 1);
      check("full_in_ready", in_ready, 0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_flags", obs, 0);
      check("mid_rst_in_ready", in_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_ghost", out_valid, 0);
      end
      run_one(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fma_operand_classify.md
Name: fma_operand_classify

Overview:
- Two-stage pipelined classifier for the FMA unit; sits directly upstream of the FMA sign/special-case logic.
- Decodes operands X, Y, Z (IEEE-754 binary, default double) and the rounding mode.
- Produces the flags the sign stage consumes: signs, xinf, yinf, inf, nan, invalid, killprod, rm.
- Uses a valid/ready handshake so the FMA pipeline can stall without losing operands.

Parameters:
FLEN, 64, operand width in bits
NE, 11, exponent width (NF = FLEN-NE-1 fraction bits)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand triple valid
in_ready  out  1  block can accept operands this cycle
x  in  FLEN  multiplicand
y  in  FLEN  multiplier
z  in  FLEN  addend
frm  in  3  rounding mode (RISC-V encoding)
out_valid  out  1  classification valid
out_ready  in  1  consumer accepts this cycle
xsign, ysign, zsign  out  1 each  operand sign bits (1 = negative)
xinf, yinf  out  1 each  X or Y is infinity
inf  out  1  any operand is infinity
nan  out  1  any operand is NaN
snan  out  1  any operand is signalling NaN
invalid  out  1  IEEE invalid-operation condition
killprod  out  1  product forced to zero (X or Y is zero)
rm  out  1  round toward minus infinity (frm == 3'b010)

Behaviour:
- Reset (reset_n low, asynchronous): s1_valid = s2_valid = 0; out_valid = 0; all flag outputs = 0; in_ready = 1 while in reset.
- Reset mid-operation discards any in-flight operands. No output is produced for them after reset releases.
- Stage 1, per operand, registered on transfer (in_valid & in_ready):
  - sign = msb
  - expmax = exponent all ones
  - expzero = exponent all zeros
  - fraczero = fraction zero
  - fracmsb = top fraction bit
  - rm = (frm == 3'b010)
- Stage 2, combinational from stage-1 registers, registered into output registers on stage-1 → stage-2 transfer:
  - opinf = expmax & fraczero
  - opnan = expmax & ~fraczero
  - opsnan = opnan & ~fracmsb
  - opzero = expzero & fraczero; subnormals are not zero
  - inf = xinf | yinf | zinf
  - nan = xnan | ynan | znan
  - snan = OR of opsnan
  - killprod = xzero | yzero
  - invalid = snan | (xinf & yzero) | (yinf & xzero) | ((xinf|yinf) & zinf & (xsign ^ ysign ^ zsign) & ~xnan & ~ynan)
  - inf*0 is invalid even when z is a quiet NaN.
- Handshake:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv; this is a combinational ready path, with no skid buffer.
  - Stage 1 loads on in_valid & in_ready. s1_valid next = in_valid when s1_adv, else it holds.
  - Stage 2 loads from stage 1 when s1_valid & s2_adv. s2_valid next = s1_valid when s2_adv, else it holds.
  - out_valid = s2_valid.
  - Outputs must stay stable while out_valid & ~out_ready.
- Latency: 2 cycles from input acceptance to out_valid when unstalled. Throughput: 1 triple per cycle.
- Simultaneous accept and emit with a full pipe (out_ready = 1, in_valid = 1) must not lose or duplicate data.
- Bubbles propagate: the register contents of invalid stages are don't-care, but out_valid must be 0 for them.
- No flag depends on frm except rm.

Test Plan:
- Reset release, then x=0x3FF0000000000000, y=0x4000000000000000, z=0xBFF0000000000000, frm=0, in_valid pulse → out_valid exactly 2 cycles later. All flags 0; xsign=0, ysign=0, zsign=1; rm=0.
- x=0x7FF0000000000000, y=0x0000000000000000, z=0x3FF0000000000000 → xinf=1, inf=1, killprod=1, invalid=1, nan=0.
- x=+inf, y=0x3FF0000000000000, z=0xFFF0000000000000 → invalid=1. Repeat with z=+inf → invalid=0, inf=1.
- z=0x7FF0000000000001 (sNaN), x=y=1.0, frm=3'b010 → nan=1, snan=1, invalid=1, rm=1. Repeat with z=0x7FF8000000000000 (qNaN) → nan=1, snan=0, invalid=0.
- Stream 4 back-to-back triples with out_ready held 0 for 3 cycles after the first out_valid:
  - in_ready drops after 2 accepted, and outputs stay stable.
  - Releasing out_ready yields all 4 results in order, with no gaps.
- Pipeline full, then reset_n asserted low for 1 cycle → out_valid=0 immediately. The next result seen is only from a triple accepted after reset release.
